// File: rtl/ov7670_cfg_pkg.sv
// Shared types and constants for the OV7670 SCCB register-configuration writer.
package ov7670_cfg_pkg;

    // Configuration sequencer states
    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_STARTUP,
        SEQ_FETCH,
        SEQ_WRITE,
        SEQ_RST_WAIT,
        SEQ_GAP,
        SEQ_DONE
    } seq_state_t;

    // SCCB bit-engine phases
    typedef enum logic [1:0] {
        ENG_IDLE,
        ENG_START,
        ENG_BITS,
        ENG_STOP
    } eng_state_t;

    // One 3-phase SCCB write: device ID, register address, register value
    typedef struct packed {
        logic [7:0] id;
        logic [7:0] reg_addr;
        logic [7:0] val;
    } sccb_wr_t;

    localparam logic [15:0]  CFG_END           = 16'hFFFF;
    localparam logic [7:0]   REG_COM7          = 8'h12;
    localparam int unsigned  COM7_RESET_BIT    = 7;
    localparam int unsigned  SCCB_BITS_PER_TXN = 27;

endpackage

// File: rtl/sccb_write_phase3.sv
// SCCB 3-phase write bit engine: start, 27 bit slots (3 bytes + don't-care), stop.
module sccb_write_phase3
    import ov7670_cfg_pkg::*;
#(
    parameter int unsigned QUARTER = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     wr_go,
    input  sccb_wr_t wr,
    output logic     wr_done,
    output logic     sioc,
    output logic     siod_oe
);

    localparam int unsigned QTR    = (QUARTER < 1) ? 1 : QUARTER;
    localparam int unsigned TICK_W = (QTR > 1) ? $clog2(QTR) : 1;
    localparam int unsigned BIT_W  = $clog2(SCCB_BITS_PER_TXN);
    localparam int unsigned FR_W   = SCCB_BITS_PER_TXN;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(QTR - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SCCB_BITS_PER_TXN - 1);

    eng_state_t        state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [1:0]        sub_q, sub_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [FR_W-1:0]   frame_q, frame_d;
    logic              sioc_d, siod_oe_d, wr_done_d;
    logic              tick_last;

    // State, counters and registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENG_IDLE;
            tick_q  <= '0;
            sub_q   <= '0;
            bit_q   <= '0;
            frame_q <= '0;
            sioc    <= 1'b1;
            siod_oe <= 1'b0;
            wr_done <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            sub_q   <= sub_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            sioc    <= sioc_d;
            siod_oe <= siod_oe_d;
            wr_done <= wr_done_d;
        end
    end

    // Quarter sequencing; outputs are the levels for the quarter being entered
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        sub_d     = sub_q;
        bit_d     = bit_q;
        frame_d   = frame_q;
        sioc_d    = sioc;
        siod_oe_d = siod_oe;
        wr_done_d = 1'b0;
        tick_last = (tick_q == TICK_LAST);

        if (state_q != ENG_IDLE) begin
            tick_d = tick_last ? '0 : tick_q + TICK_W'(1);
        end

        case (state_q)
            ENG_IDLE: begin
                if (wr_go) begin
                    state_d   = ENG_START;
                    tick_d    = '0;
                    sub_d     = '0;
                    bit_d     = '0;
                    // Don't-care slots carry 1 so the line is released
                    frame_d   = {wr.id, 1'b1, wr.reg_addr, 1'b1, wr.val, 1'b1};
                    sioc_d    = 1'b1;
                    siod_oe_d = 1'b0;
                end
            end
            ENG_START: begin
                if (tick_last) begin
                    case (sub_q)
                        2'd0: begin
                            sub_d     = 2'd1;
                            siod_oe_d = 1'b1;
                        end
                        2'd1: begin
                            sub_d  = 2'd2;
                            sioc_d = 1'b0;
                        end
                        default: begin
                            state_d   = ENG_BITS;
                            sub_d     = 2'd0;
                            sioc_d    = 1'b0;
                            siod_oe_d = ~frame_q[FR_W-1];
                        end
                    endcase
                end
            end
            ENG_BITS: begin
                if (tick_last) begin
                    case (sub_q)
                        2'd0: sub_d = 2'd1;
                        2'd1: begin
                            sub_d  = 2'd2;
                            sioc_d = 1'b1;
                        end
                        2'd2: sub_d = 2'd3;
                        default: begin
                            sub_d  = 2'd0;
                            sioc_d = 1'b0;
                            if (bit_q == BIT_LAST) begin
                                state_d   = ENG_STOP;
                                siod_oe_d = 1'b1;
                            end else begin
                                bit_d     = bit_q + BIT_W'(1);
                                frame_d   = {frame_q[FR_W-2:0], 1'b0};
                                siod_oe_d = ~frame_q[FR_W-2];
                            end
                        end
                    endcase
                end
            end
            ENG_STOP: begin
                if (tick_last) begin
                    case (sub_q)
                        2'd0: begin
                            sub_d  = 2'd1;
                            sioc_d = 1'b1;
                        end
                        2'd1: begin
                            sub_d     = 2'd2;
                            siod_oe_d = 1'b0;
                        end
                        default: begin
                            state_d   = ENG_IDLE;
                            sub_d     = 2'd0;
                            wr_done_d = 1'b1;
                        end
                    endcase
                end
            end
            default: state_d = ENG_IDLE;
        endcase
    end

endmodule

// File: rtl/ov7670_sccb_config_writer.sv
// Walks the OV7670 config ROM and writes every entry over SCCB until the end marker.
module ov7670_sccb_config_writer
    import ov7670_cfg_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ        = 25_000_000,
    parameter int unsigned SCCB_FREQ_HZ       = 100_000,
    parameter logic [7:0]  DEVICE_ID          = 8'h42,
    parameter int unsigned ADDR_WIDTH         = 7,
    parameter int unsigned DATA_WIDTH         = 16,
    parameter int unsigned STARTUP_CYCLES     = 1_000_000,
    parameter int unsigned GAP_CYCLES         = 2_500,
    parameter int unsigned RESET_DELAY_CYCLES = 25_000
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Start,
    output logic [ADDR_WIDTH-1:0] Rom_Addr,
    input  logic [DATA_WIDTH-1:0] Rom_Data,
    output logic                  Sioc,
    output logic                  Siod_Oe,
    output logic                  Busy,
    output logic                  Done
);

    localparam int unsigned QRAW    = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam int unsigned QUARTER = (QRAW < 1) ? 1 : QRAW;

    localparam int unsigned MAX_A   = (STARTUP_CYCLES > GAP_CYCLES) ? STARTUP_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_DLY = (MAX_A > RESET_DELAY_CYCLES) ? MAX_A : RESET_DELAY_CYCLES;
    localparam int unsigned DLY_W   = $clog2(MAX_DLY + 1);

    localparam logic [DLY_W-1:0] STARTUP_LAST = DLY_W'((STARTUP_CYCLES > 0) ? STARTUP_CYCLES - 1 : 0);
    localparam logic [DLY_W-1:0] GAP_LAST     = DLY_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [DLY_W-1:0] RST_LAST     = DLY_W'((RESET_DELAY_CYCLES > 0) ? RESET_DELAY_CYCLES - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

    seq_state_t            state_q, state_d;
    logic [DLY_W-1:0]      dly_q, dly_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  busy_d, done_d;
    logic                  wr_go, wr_go_d;
    logic [7:0]            reg_q, reg_d, val_q, val_d;
    logic [15:0]           entry;
    logic                  wr_done;
    sccb_wr_t              wr_payload;

    assign entry      = 16'(Rom_Data);
    assign wr_payload = {DEVICE_ID, reg_q, val_q};

    // Sequencer state, delay counter and registered outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= SEQ_IDLE;
            dly_q    <= '0;
            Rom_Addr <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            wr_go    <= 1'b0;
            reg_q    <= '0;
            val_q    <= '0;
        end else begin
            state_q  <= state_d;
            dly_q    <= dly_d;
            Rom_Addr <= addr_d;
            Busy     <= busy_d;
            Done     <= done_d;
            wr_go    <= wr_go_d;
            reg_q    <= reg_d;
            val_q    <= val_d;
        end
    end

    // Next-state logic: startup wait, fetch, write, optional soft-reset wait, gap
    always_comb begin
        state_d = state_q;
        dly_d   = '0;
        addr_d  = Rom_Addr;
        busy_d  = Busy;
        done_d  = Done;
        wr_go_d = 1'b0;
        reg_d   = reg_q;
        val_d   = val_q;

        case (state_q)
            SEQ_IDLE, SEQ_DONE: begin
                if (Start) begin
                    state_d = SEQ_STARTUP;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            SEQ_STARTUP: begin
                if (dly_q == STARTUP_LAST) state_d = SEQ_FETCH;
                else                       dly_d   = dly_q + DLY_W'(1);
            end
            SEQ_FETCH: begin
                reg_d = entry[15:8];
                val_d = entry[7:0];
                if (entry == CFG_END) begin
                    state_d = SEQ_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = SEQ_WRITE;
                    wr_go_d = 1'b1;
                end
            end
            SEQ_WRITE: begin
                if (wr_done) begin
                    if (reg_q == REG_COM7 && val_q[COM7_RESET_BIT]) state_d = SEQ_RST_WAIT;
                    else                                           state_d = SEQ_GAP;
                end
            end
            SEQ_RST_WAIT: begin
                if (dly_q == RST_LAST) state_d = SEQ_GAP;
                else                   dly_d   = dly_q + DLY_W'(1);
            end
            SEQ_GAP: begin
                if (dly_q == GAP_LAST) begin
                    // A ROM without an end marker stops at the last address
                    if (Rom_Addr == ADDR_LAST) begin
                        state_d = SEQ_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SEQ_FETCH;
                        addr_d  = Rom_Addr + ADDR_WIDTH'(1);
                    end
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    sccb_write_phase3 #(
        .QUARTER (QUARTER)
    ) u_sccb (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .wr_go   (wr_go),
        .wr      (wr_payload),
        .wr_done (wr_done),
        .sioc    (Sioc),
        .siod_oe (Siod_Oe)
    );

endmodule

// File: tb/tb_ov7670_sccb_config_writer.sv
// Scoreboard bench: stimulus queues expected SCCB frames, a bus monitor decodes and checks them.
module tb_ov7670_sccb_config_writer;

    localparam int unsigned QUARTER = 1;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [6:0]  Rom_Addr;
    logic [15:0] Rom_Data;
    logic        Sioc, Siod_Oe, Busy, Done;

    logic [15:0] rom [128];
    assign Rom_Data = rom[Rom_Addr];

    always #5 Clk = ~Clk;

    ov7670_sccb_config_writer #(
        .CLK_FREQ_HZ        (400),
        .SCCB_FREQ_HZ       (100),
        .DEVICE_ID          (8'h42),
        .ADDR_WIDTH         (7),
        .DATA_WIDTH         (16),
        .STARTUP_CYCLES     (4),
        .GAP_CYCLES         (2),
        .RESET_DELAY_CYCLES (8)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Start    (Start),
        .Rom_Addr (Rom_Addr),
        .Rom_Data (Rom_Data),
        .Sioc     (Sioc),
        .Siod_Oe  (Siod_Oe),
        .Busy     (Busy),
        .Done     (Done)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          txn_cnt = 0;
    int          rise_cnt = 0;
    logic [26:0] exp_q [$];
    int          gap_q [$];

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected bit stream: ID, reg, val, each followed by a released don't-care bit
    function automatic logic [26:0] frame(input logic [15:0] e);
        return {8'h42, 1'b1, e[15:8], 1'b1, e[7:0], 1'b1};
    endfunction

    // Bus monitor: decodes start/stop, samples bits on SIOC rise, checks protocol
    initial begin : monitor
        logic        p_sioc, p_siod, siod, in_txn, stop_seen;
        logic [27:0] bits;
        int          t_start, t_rise, t_stop;
        p_sioc = 1'b1; p_siod = 1'b1; in_txn = 1'b0; stop_seen = 1'b0;
        bits = '0; t_start = 0; t_rise = 0; t_stop = 0;
        forever begin
            @(negedge Clk);
            siod = ~Siod_Oe;
            if (!Rst_n) begin
                in_txn   = 1'b0;
                rise_cnt = 0;
            end else begin
                if (Sioc && p_sioc && siod != p_siod) begin
                    if (!siod) begin
                        if (in_txn) begin
                            n_vec++; n_err++;
                            $display("FAIL siod_fall_while_sioc_high: at bit %0d got fall, want stable", rise_cnt);
                        end
                        in_txn   = 1'b1;
                        rise_cnt = 0;
                        bits     = '0;
                        t_start  = cyc;
                        if (stop_seen) gap_q.push_back(cyc - t_stop);
                    end else if (!in_txn) begin
                        n_vec++; n_err++;
                        $display("FAIL siod_rise_outside_txn: got rise, want stable");
                    end else begin
                        chk("stop_spacing", 32'(cyc - t_rise), 32'(QUARTER));
                        chk("rise_count", 32'(rise_cnt), 32'd28);
                        if (exp_q.size() == 0) begin
                            n_vec++; n_err++;
                            $display("FAIL unexpected_txn: got frame 0x%0h, want none", bits[27:1]);
                        end else begin
                            chk("frame", 32'(bits[27:1]), 32'(exp_q.pop_front()));
                        end
                        txn_cnt++;
                        in_txn    = 1'b0;
                        stop_seen = 1'b1;
                        t_stop    = cyc;
                    end
                end
                if (in_txn && p_sioc && !Sioc && rise_cnt == 0)
                    chk("start_spacing", 32'(cyc - t_start), 32'(QUARTER));
                if (in_txn && !p_sioc && Sioc) begin
                    rise_cnt++;
                    bits   = {bits[26:0], siod};
                    t_rise = cyc;
                end
            end
            p_sioc = Sioc;
            p_siod = siod;
        end
    end

    task automatic pulse_start();
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (!Done && n < budget) begin
            @(negedge Clk);
            n++;
        end
        if (!Done) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: Done=0 after %0d cycles, want 1", name, budget);
        end
        repeat (3) @(negedge Clk);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'hFFFF;
    endtask

    initial begin : stim
        int t0, gmin, gmax, n;
        clear_rom();

        // Reset values while held in reset
        #23;
        chk("rst_addr", 32'(Rom_Addr), 32'd0);
        chk("rst_sioc", 32'(Sioc), 32'd1);
        chk("rst_oe", 32'(Siod_Oe), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        @(negedge Clk); Rst_n = 1'b1;
        repeat (2) @(negedge Clk);

        // Single write then end marker
        clear_rom();
        rom[0] = 16'h1204;
        exp_q.push_back(27'b01000010_1_00010010_1_00000100_1);
        t0 = txn_cnt;
        pulse_start();
        chk("t1_busy", 32'(Busy), 32'd1);
        chk("t1_done_low", 32'(Done), 32'd0);
        wait_done(1000, "t1");
        chk("t1_txns", 32'(txn_cnt - t0), 32'd1);
        chk("t1_done", 32'(Done), 32'd1);
        chk("t1_busy_end", 32'(Busy), 32'd0);
        chk("t1_addr", 32'(Rom_Addr), 32'd1);

        // Soft reset write followed by a plain write; Start during WRITE ignored
        clear_rom();
        rom[0] = 16'h1280;
        rom[1] = 16'h1180;
        exp_q.push_back(frame(16'h1280));
        exp_q.push_back(frame(16'h1180));
        gap_q.delete();
        t0 = txn_cnt;
        pulse_start();
        n = 0;
        while (rise_cnt < 3 && n < 1000) begin @(negedge Clk); #1; n++; end
        chk("t2_reached_write", 32'(rise_cnt >= 3), 32'd1);
        pulse_start();
        wait_done(2000, "t2");
        chk("t2_txns", 32'(txn_cnt - t0), 32'd2);
        chk("t2_addr", 32'(Rom_Addr), 32'd2);
        chk("t2_done", 32'(Done), 32'd1);
        if (gap_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL t2_gap: got no gap, want one");
        end else begin
            chk("t2_gap_min", 32'(gap_q[gap_q.size()-1] >= 13), 32'd1);
            chk("t2_gap_max", 32'(gap_q[gap_q.size()-1] <= 20), 32'd1);
        end

        // No end marker: all 128 entries written, no wrap-around
        for (int i = 0; i < 128; i++) begin
            rom[i] = {8'h30, 8'(i)};
            exp_q.push_back(frame({8'h30, 8'(i)}));
        end
        gap_q.delete();
        t0 = txn_cnt;
        pulse_start();
        wait_done(40000, "t4");
        chk("t4_txns", 32'(txn_cnt - t0), 32'd128);
        chk("t4_addr", 32'(Rom_Addr), 32'd127);
        chk("t4_done", 32'(Done), 32'd1);
        gmin = 1000; gmax = 0;
        for (int i = 1; i < gap_q.size(); i++) begin
            if (gap_q[i] < gmin) gmin = gap_q[i];
            if (gap_q[i] > gmax) gmax = gap_q[i];
        end
        chk("t4_gap_min", 32'(gmin >= 6), 32'd1);
        chk("t4_gap_max", 32'(gmax <= 10), 32'd1);
        repeat (10) @(negedge Clk);
        chk("t4_no_wrap", 32'(Rom_Addr), 32'd127);

        // Asynchronous reset in the middle of the data byte
        clear_rom();
        rom[0] = 16'h3A00;
        exp_q.push_back(frame(16'h3A00));
        pulse_start();
        n = 0;
        while (rise_cnt != 21 && n < 1000) begin @(negedge Clk); #1; n++; end
        chk("t5_reached_data", 32'(rise_cnt), 32'd21);
        @(negedge Clk);
        @(negedge Clk);
        #2;
        chk("t5_pre_sioc", 32'(Sioc), 32'd0);
        chk("t5_pre_oe", 32'(Siod_Oe), 32'd1);
        Rst_n = 1'b0;
        #1;
        chk("t5_rst_sioc", 32'(Sioc), 32'd1);
        chk("t5_rst_oe", 32'(Siod_Oe), 32'd0);
        chk("t5_rst_busy", 32'(Busy), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge Clk);
        chk("t5_rst_addr", 32'(Rom_Addr), 32'd0);
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);
        exp_q.push_back(frame(16'h3A00));
        t0 = txn_cnt;
        pulse_start();
        wait_done(1000, "t5");
        chk("t5_txns", 32'(txn_cnt - t0), 32'd1);
        chk("t5_addr", 32'(Rom_Addr), 32'd1);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
